// File: rtl/keypad_matrix_ctrl.sv
// Column-scanned ROWS x COLS keypad: 2-flop row sync, per-frame debounce, press/release events into a FWFT FIFO.
// Latency: an event is visible one cycle after its EMIT slot; a commit needs DEBOUNCE identical frames (COLS*SCAN_DIV+1 cycles each).
// Backpressure: evt_ready=0 stalls the head; when the FIFO is full a new event is dropped, overflow sticks, key_state still tracks.
module keypad_matrix_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 4,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int CODE_W    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CODE_W-1:0]    evt_code,
  output logic                 evt_press,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 overflow,
  input  logic                 clr_ovf
);

  localparam int NKEYS = ROWS * COLS;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = CODE_W + 1;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Row synchroniser
  logic [ROWS-1:0]  rows_s1_q, rows_s1_d;
  logic [ROWS-1:0]  rows_s2_q, rows_s2_d;

  // Scanner / debouncer state
  state_t           state_q, state_d;
  logic             run_q, run_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CODE_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [NKEYS-1:0] snap_q, snap_d;
  logic [NKEYS-1:0] prev_q, prev_d;
  logic [NKEYS-1:0] key_state_q, key_state_d;
  logic [COLS-1:0]  cols_q, cols_d;
  logic             overflow_q, overflow_d;

  // Event push into the FIFO
  logic             push_vld;
  logic             push_rdy;
  logic             push_press;
  logic [EW-1:0]    push_dat;

  // Event FIFO storage
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    mem_d [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             fifo_empty;
  logic             fifo_full;
  logic             evt_pop;
  logic             fifo_wr;
  logic [EW-1:0]    head_dat;

  // Row returns are asynchronous to clk: two flops before use.
  always_comb begin
    rows_s1_d = rows;
    rows_s2_d = rows_s1_q;
  end

  // Scan / debounce / emit FSM; run_q holds the FSM for the first cycle out of reset so cols can leave reset idle.
  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    col_d       = col_q;
    div_d       = div_q;
    k_d         = k_q;
    stable_d    = stable_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    key_state_d = key_state_q;
    push_vld    = 1'b0;
    push_press  = 1'b0;

    if (run_q) begin
      case (state_q)
        SCAN: begin
          if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            // Last cycle of the slot: the synchronised rows now reflect this column.
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                if (col_q == COL_W'(c)) begin
                  snap_d[r*COLS + c] = ~rows_s2_q[r];
                end
              end
            end
            if (col_q == COL_W'(COLS - 1)) begin
              col_d   = '0;
              state_d = CHECK;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end

        CHECK: begin
          if (snap_q == prev_q) begin
            if (stable_q >= CNT_W'(DEBOUNCE)) begin
              stable_d = CNT_W'(DEBOUNCE);
            end else begin
              stable_d = stable_q + CNT_W'(1);
            end
          end else begin
            stable_d = CNT_W'(1);
          end
          prev_d = snap_q;
          if ((stable_d >= CNT_W'(DEBOUNCE)) && (snap_q != key_state_q)) begin
            state_d = EMIT;
            k_d     = '0;
          end else begin
            state_d = SCAN;
            col_d   = '0;
            div_d   = '0;
          end
        end

        EMIT: begin
          // One key per cycle, ascending code, so a commit's events come out in code order.
          for (int i = 0; i < NKEYS; i++) begin
            if ((k_q == CODE_W'(i)) && (snap_q[i] != key_state_q[i])) begin
              push_vld       = 1'b1;
              push_press     = snap_q[i];
              key_state_d[i] = snap_q[i];
            end
          end
          if (k_q == CODE_W'(NKEYS - 1)) begin
            k_d     = '0;
            state_d = SCAN;
            col_d   = '0;
            div_d   = '0;
          end else begin
            k_d = k_q + CODE_W'(1);
          end
        end

        default: begin
          state_d = SCAN;
          col_d   = '0;
          div_d   = '0;
          k_d     = '0;
        end
      endcase
    end

    // Column drive is registered from the next state so pins never glitch; idle (all 1) outside SCAN.
    for (int c = 0; c < COLS; c++) begin
      cols_d[c] = !((state_d == SCAN) && (col_d == COL_W'(c)));
    end
  end

  assign push_dat = {k_q, push_press};

  // FIFO pointers and storage; a push into a full FIFO is taken only when the head pops in the same cycle.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    evt_pop    = !fifo_empty && evt_ready;
    push_rdy   = !fifo_full || evt_pop;
    fifo_wr    = push_vld && push_rdy;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (evt_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    // Outputs are forced to zero when empty so stale storage is never presented.
    head_dat = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Sticky drop flag; a drop in the same cycle as clr_ovf wins.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (push_vld && !push_rdy) begin
      overflow_d = 1'b1;
    end
  end

  // State registers; reset discards everything including in-flight events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_s1_q   <= '1;
      rows_s2_q   <= '1;
      state_q     <= SCAN;
      run_q       <= 1'b0;
      col_q       <= '0;
      div_q       <= '0;
      k_q         <= '0;
      stable_q    <= '0;
      snap_q      <= '0;
      prev_q      <= '0;
      key_state_q <= '0;
      cols_q      <= '1;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rows_s1_q   <= rows_s1_d;
      rows_s2_q   <= rows_s2_d;
      state_q     <= state_d;
      run_q       <= run_d;
      col_q       <= col_d;
      div_q       <= div_d;
      k_q         <= k_d;
      stable_q    <= stable_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      key_state_q <= key_state_d;
      cols_q      <= cols_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign cols                  = cols_q;
  assign evt_valid             = !fifo_empty;
  assign {evt_code, evt_press} = head_dat;
  assign key_state             = key_state_q;
  assign overflow              = overflow_q;

endmodule

// File: tb/tb_keypad_matrix_ctrl.sv
// Bench for keypad_matrix_ctrl: keypad model, table of key patterns with expected events, plus timing/overflow/stall/reset sequences.
// Latency: checks exact press-to-evt_valid cycle count out of reset.
// Backpressure: exercises evt_ready held low, random stalls and FIFO overflow.
module tb_keypad_matrix_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NK   = ROWS * COLS;
  // Out of reset: 2 frames of 17 + CHECK at 51, EMIT k=0..9 at 52..61, visible at cycle 62.
  localparam int PRESS9_LAT = 62;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ROWS-1:0] rows;
  logic [COLS-1:0] cols;
  logic            evt_valid;
  logic            evt_ready;
  logic [3:0]      evt_code;
  logic            evt_press;
  logic [NK-1:0]   key_state;
  logic            overflow;
  logic            clr_ovf;

  logic [NK-1:0]   keys;
  int              n_assert = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  logic [4:0]      evq[$];
  int              evt_cyc[$];
  int              rd_idx   = 0;

  typedef struct {
    logic [NK-1:0]   keys;
    logic [NK-1:0]   exp_state;
    int              n_evt;
    logic [3:0][4:0] evt;
    bit              stall;
    bit              consec;
  } vec_t;

  vec_t vt [5];

  keypad_matrix_ctrl #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_press(evt_press), .key_state(key_state), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: a held key pulls its row low while its column is driven.
  always_comb begin
    rows = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!cols[c] && keys[r*COLS + c]) rows[r] = 1'b0;
      end
    end
  end

  // Record every accepted event with its cycle number.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      evq.push_back({evt_code, evt_press});
      evt_cyc.push_back(cyc);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_evt(input string nm, input int j, input logic [4:0] exp);
    if (rd_idx + j < evq.size()) check(nm, 32'(evq[rd_idx + j]), 32'(exp));
    else check({nm, "_missing"}, 32'(0), 32'(1));
  endtask

  // Release reset and measure cycles until the held key 9 shows up.
  task automatic measure(input string nm);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    rst_n = 1'b1;
    while (!found && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check({nm, "_first_col"}, 32'(cols), 32'(4'b1110));
      if (evt_valid) begin
        found = 1'b1;
        check({nm, "_latency"}, 32'(n), 32'(PRESS9_LAT));
        check({nm, "_code"}, 32'(evt_code), 32'd9);
        check({nm, "_press"}, 32'(evt_press), 32'd1);
      end
    end
    if (!found) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s_timeout: actual=no event expected=event within 200 cycles", nm);
    end
  endtask

  initial begin
    bit         found;
    int         n;
    logic       prev_stall;
    logic [4:0] prev_head;
    logic [4:0] exp_rand [8];

    // Vector table: key pattern -> debounced state and event list.
    vt[0].keys = 16'h0000; vt[0].exp_state = 16'h0000; vt[0].n_evt = 1;
    vt[0].evt  = '0; vt[0].evt[0] = {4'd9, 1'b0}; vt[0].stall = 0; vt[0].consec = 0;
    vt[1].keys = 16'h4008; vt[1].exp_state = 16'h4008; vt[1].n_evt = 2;
    vt[1].evt  = '0; vt[1].evt[0] = {4'd3, 1'b1}; vt[1].evt[1] = {4'd14, 1'b1};
    vt[1].stall = 1; vt[1].consec = 1;
    vt[2].keys = 16'h0008; vt[2].exp_state = 16'h0008; vt[2].n_evt = 1;
    vt[2].evt  = '0; vt[2].evt[0] = {4'd14, 1'b0}; vt[2].stall = 0; vt[2].consec = 0;
    vt[3].keys = 16'h8001; vt[3].exp_state = 16'h8001; vt[3].n_evt = 3;
    vt[3].evt  = '0; vt[3].evt[0] = {4'd0, 1'b1}; vt[3].evt[1] = {4'd3, 1'b0};
    vt[3].evt[2] = {4'd15, 1'b1}; vt[3].stall = 0; vt[3].consec = 0;
    vt[4].keys = 16'h0000; vt[4].exp_state = 16'h0000; vt[4].n_evt = 2;
    vt[4].evt  = '0; vt[4].evt[0] = {4'd0, 1'b0}; vt[4].evt[1] = {4'd15, 1'b0};
    vt[4].stall = 0; vt[4].consec = 0;

    rst_n     = 1'b0;
    keys      = 16'h0200;
    evt_ready = 1'b1;
    clr_ovf   = 1'b0;
    wcyc(3);

    // Reset values
    check("rst_cols", 32'(cols), 32'hF);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_code", 32'(evt_code), 32'd0);
    check("rst_press", 32'(evt_press), 32'd0);
    check("rst_key_state", 32'(key_state), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single press of key 9 held from reset: exact latency, one event.
    measure("press9");
    wcyc(3);
    check("press9_count", 32'(evq.size() - rd_idx), 32'd1);
    check_evt("press9_evt", 0, {4'd9, 1'b1});
    check("press9_state", 32'(key_state), 32'h0200);
    rd_idx = evq.size();

    // Table-driven key patterns
    for (int i = 0; i < 5; i++) begin
      evt_ready = !vt[i].stall;
      keys      = vt[i].keys;
      wcyc(200);
      if (vt[i].stall) begin
        evt_ready = 1'b1;
        wcyc(6);
      end
      check($sformatf("tbl%0d_state", i), 32'(key_state), 32'(vt[i].exp_state));
      check($sformatf("tbl%0d_count", i), 32'(evq.size() - rd_idx), 32'(vt[i].n_evt));
      for (int j = 0; j < vt[i].n_evt; j++)
        check_evt($sformatf("tbl%0d_evt%0d", i, j), j, vt[i].evt[j]);
      if (vt[i].consec && (rd_idx + 1 < evt_cyc.size()))
        check($sformatf("tbl%0d_consec", i), 32'(evt_cyc[rd_idx+1] - evt_cyc[rd_idx]), 32'd1);
      rd_idx = evq.size();
    end

    // Bounce: key 9 alternates every frame, then holds.
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      wcyc(17);
    end
    check("bounce_no_evt", 32'(evq.size() - rd_idx), 32'd0);
    check("bounce_state", 32'(key_state), 32'd0);
    keys = 16'h0200;
    wcyc(200);
    check("bounce_count", 32'(evq.size() - rd_idx), 32'd1);
    check_evt("bounce_evt", 0, {4'd9, 1'b1});
    rd_idx = evq.size();
    keys = 16'h0000;
    wcyc(200);
    check_evt("bounce_rel", 0, {4'd9, 1'b0});
    rd_idx = evq.size();

    // Backpressure and overflow: 6 presses into a 4-deep FIFO.
    evt_ready = 1'b0;
    keys      = 16'h14A6;
    wcyc(200);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_state", 32'(key_state), 32'h14A6);
    check("ovf_valid", 32'(evt_valid), 32'd1);
    check("ovf_head", 32'({evt_code, evt_press}), 32'({4'd1, 1'b1}));
    evt_ready = 1'b1;
    wcyc(8);
    check("ovf_drain_count", 32'(evq.size() - rd_idx), 32'd4);
    check_evt("ovf_drain0", 0, {4'd1, 1'b1});
    check_evt("ovf_drain1", 1, {4'd2, 1'b1});
    check_evt("ovf_drain2", 2, {4'd5, 1'b1});
    check_evt("ovf_drain3", 3, {4'd7, 1'b1});
    check("ovf_empty", 32'(evt_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    wcyc(1);
    clr_ovf = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    rd_idx = evq.size();
    keys = 16'h0000;
    wcyc(200);
    check("rel6_count", 32'(evq.size() - rd_idx), 32'd6);
    rd_idx = evq.size();

    // Random stalls: head must hold while stalled; no loss or duplication.
    exp_rand[0] = {4'd4, 1'b1};  exp_rand[1] = {4'd6, 1'b1};
    exp_rand[2] = {4'd8, 1'b1};  exp_rand[3] = {4'd13, 1'b1};
    exp_rand[4] = {4'd4, 1'b0};  exp_rand[5] = {4'd6, 1'b0};
    exp_rand[6] = {4'd8, 1'b0};  exp_rand[7] = {4'd13, 1'b0};
    prev_stall = 1'b0;
    prev_head  = '0;
    for (int j = 0; j < 500; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) keys = 16'h2150;
      if (j == 250) keys = 16'h0000;
      evt_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) check("stall_hold", 32'({evt_valid, evt_code, evt_press}), 32'({1'b1, prev_head}));
      prev_stall = evt_valid && !evt_ready;
      prev_head  = {evt_code, evt_press};
    end
    @(posedge clk);
    #1;
    evt_ready = 1'b1;
    wcyc(20);
    check("rand_count", 32'(evq.size() - rd_idx), 32'd8);
    for (int j = 0; j < 8; j++) check_evt($sformatf("rand_evt%0d", j), j, exp_rand[j]);
    check("rand_no_ovf", 32'(overflow), 32'd0);
    rd_idx = evq.size();

    // Reset in the middle of EMIT, then the held key re-emits.
    keys  = 16'h0200;
    found = 1'b0;
    n     = 0;
    while (!found && n < 300) begin
      wcyc(1);
      n++;
      if (evt_valid) found = 1'b1;
    end
    check("emit_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_cols", 32'(cols), 32'hF);
    check("arst_valid", 32'(evt_valid), 32'd0);
    check("arst_code", 32'(evt_code), 32'd0);
    check("arst_press", 32'(evt_press), 32'd0);
    check("arst_key_state", 32'(key_state), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    wcyc(2);
    measure("repress9");
    wcyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
